// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the memory-mapped I/O bridge.
package mmio_pkg;

  localparam int unsigned IN_OFF     = 0;
  localparam int unsigned STATUS_OFF = 16;
  localparam int unsigned OUT_OFF    = 32;
  localparam int unsigned MAX_CH     = 16;

  // Replicate bit (in_w-1) of sample into every higher bit position.
  function automatic logic [63:0] sign_ext(input logic [63:0] sample, input int in_w);
    logic [63:0] res;
    logic        sgn;
    sgn = 1'b0;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      if (i == in_w - 1) sgn = sample[i];
    end
    for (int i = 0; i < 64; i++) begin
      res[i] = (i < in_w) ? sample[i] : sgn;
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_in_channel.sv
// One sensor input channel: captured sample plus a sticky new-sample flag.
module mmio_in_channel #(
  parameter int IN_W = 9
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_sample,
  input  logic            rd_clr,
  output logic [IN_W-1:0] sample_q,
  output logic            flag_q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      if (in_valid) sample_q <= in_sample;
      // A capture in the same cycle as the clearing read keeps the flag set.
      if (in_valid)    flag_q <= 1'b1;
      else if (rd_clr) flag_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Splits CPU data accesses between RAM and a small bank of sensor/output
// registers, returning I/O reads with the same one-cycle latency as RAM.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                ADDR_W  = 12,
  parameter int                DATA_W  = 32,
  parameter int                N_IN    = 2,
  parameter int                IN_W    = 9,
  parameter int                N_OUT   = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = 12'hF00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_we,
  input  logic                    cpu_re,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic                    ram_we,
  input  logic [DATA_W-1:0]       ram_rdata,
  input  logic [N_IN*IN_W-1:0]    in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_strobe
);

  logic              is_io;
  logic [ADDR_W-1:0] off;
  logic [31:0]       off_w;
  logic [N_IN-1:0]   rd_clr;
  logic [N_IN-1:0]   flag;
  logic [IN_W-1:0]   sample_q [N_IN];
  logic [N_OUT-1:0]  we_out;
  logic [DATA_W-1:0] out_reg [N_OUT];
  logic [DATA_W-1:0] io_val;
  logic              is_io_q;
  logic [DATA_W-1:0] io_val_q;

  assign is_io     = (cpu_addr >= IO_BASE);
  assign off       = cpu_addr - IO_BASE;
  assign off_w     = 32'(off);
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_we && !is_io;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      mmio_in_channel #(.IN_W(IN_W)) u_ch (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid[gi]),
        .in_sample(in_data[gi*IN_W +: IN_W]),
        .rd_clr   (rd_clr[gi]),
        .sample_q (sample_q[gi]),
        .flag_q   (flag[gi])
      );
    end
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      assign out_data[gi*DATA_W +: DATA_W] = out_reg[gi];
    end
  endgenerate

  always_comb begin
    rd_clr = '0;
    we_out = '0;
    io_val = '0;
    if (is_io) begin
      for (int i = 0; i < N_IN; i++) begin
        if (off_w == 32'(IN_OFF + i)) begin
          rd_clr[i] = cpu_re;
          io_val    = DATA_W'(sign_ext(64'(sample_q[i]), IN_W));
        end
      end
      if (off_w == 32'(STATUS_OFF)) io_val = DATA_W'(flag);
      for (int j = 0; j < N_OUT; j++) begin
        if (off_w == 32'(OUT_OFF + j)) begin
          we_out[j] = cpu_we;
          io_val    = out_reg[j];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N_OUT; j++) out_reg[j] <= '0;
      out_strobe <= '0;
      is_io_q    <= 1'b0;
      io_val_q   <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (we_out[j]) out_reg[j] <= cpu_wdata;
      end
      out_strobe <= we_out;
      is_io_q    <= is_io;
      io_val_q   <= io_val;
    end
  end

  assign cpu_rdata = is_io_q ? io_val_q : ram_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed checks of the I/O bridge against a registered RAM model.
module tb_mmio_bridge;

  logic         clock = 1'b0;
  logic         reset;
  logic [11:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_we;
  logic         cpu_re;
  logic [31:0]  cpu_rdata;
  logic [11:0]  ram_addr;
  logic [31:0]  ram_wdata;
  logic         ram_we;
  logic [31:0]  ram_rdata;
  logic [17:0]  in_data;
  logic [1:0]   in_valid;
  logic [127:0] out_data;
  logic [3:0]   out_strobe;

  logic [31:0]  mem [4096];
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clock = ~clock;

  mmio_bridge dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_strobe(out_strobe)
  );

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic we, input logic re);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = we;
    cpu_re    = re;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    ram_rdata = '0;
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_out_data0", out_data[31:0], 32'h0);
    chk("rst_strobe", 32'(out_strobe), 32'h0);

    // write 5 to out_reg[0], then reset mid-cycle
    drive(12'hF20, 32'h5, 1'b1, 1'b0);
    #1;
    chk("io_wr_ram_we", 32'(ram_we), 32'h0);
    step();
    chk("out0_written", out_data[31:0], 32'h5);
    chk("out0_strobe", 32'(out_strobe), 32'h1);
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out0", out_data[31:0], 32'h0);
    chk("async_rst_strobe", 32'(out_strobe), 32'h0);
    step();
    reset = 1'b1;
    drive(12'hF20, 32'h0, 1'b0, 1'b1);
    step();
    chk("rd_f20_after_rst", cpu_rdata, 32'h0);

    // RAM pass-through
    drive(12'h010, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    chk("ram_we_on_write", 32'(ram_we), 32'h1);
    step();
    drive(12'h010, 32'h0, 1'b0, 1'b1);
    #1;
    chk("ram_we_on_read", 32'(ram_we), 32'h0);
    step();
    chk("ram_readback", cpu_rdata, 32'hDEADBEEF);

    // capture + sign extension on ch0
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    in_data  = {9'h000, 9'h1F0};
    in_valid = 2'b01;
    step();
    in_valid = 2'b00;
    drive(12'hF10, 32'h0, 1'b0, 1'b1);
    step();
    chk("status_ch0_set", cpu_rdata, 32'h1);
    drive(12'hF00, 32'h0, 1'b0, 1'b1);
    step();
    chk("ch0_sign_ext", cpu_rdata, 32'hFFFFFFF0);
    drive(12'hF10, 32'h0, 1'b0, 1'b1);
    step();
    chk("status_ch0_clr", cpu_rdata, 32'h0);

    // set/clear collision on ch1
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    in_data  = {9'h005, 9'h000};
    in_valid = 2'b10;
    step();
    in_data  = {9'h007, 9'h000};
    in_valid = 2'b10;
    drive(12'hF01, 32'h0, 1'b0, 1'b1);
    step();
    in_valid = 2'b00;
    chk("collision_old", cpu_rdata, 32'h5);
    drive(12'hF10, 32'h0, 1'b0, 1'b1);
    step();
    chk("collision_status", cpu_rdata, 32'h2);
    drive(12'hF01, 32'h0, 1'b0, 1'b1);
    step();
    chk("collision_new", cpu_rdata, 32'h7);

    // output strobes
    drive(12'hF21, 32'h140, 1'b1, 1'b0);
    step();
    chk("out1_data", out_data[63:32], 32'h140);
    chk("out1_strobe", 32'(out_strobe), 32'h2);
    drive(12'hF22, 32'hA, 1'b1, 1'b0);
    step();
    chk("out2_strobe", 32'(out_strobe), 32'h4);
    drive(12'hF23, 32'hB, 1'b1, 1'b0);
    step();
    chk("out3_strobe", 32'(out_strobe), 32'h8);
    chk("out2_data", out_data[95:64], 32'hA);
    drive(12'hF00, 32'h123, 1'b1, 1'b0);
    step();
    chk("strobe_cleared", 32'(out_strobe), 32'h0);
    drive(12'hF10, 32'h1, 1'b1, 1'b0);
    step();
    chk("ro_wr_no_strobe", 32'(out_strobe), 32'h0);
    drive(12'hF00, 32'h0, 1'b0, 1'b1);
    step();
    chk("in_reg_ignores_wr", cpu_rdata, 32'hFFFFFFF0);
    drive(12'hF10, 32'h0, 1'b0, 1'b1);
    step();
    chk("status_ignores_wr", cpu_rdata, 32'h0);
    drive(12'hF21, 32'h55, 1'b1, 1'b1);
    step();
    chk("rw_same_old", cpu_rdata, 32'h140);
    chk("rw_same_new", out_data[63:32], 32'h55);

    // unmapped and top addresses
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    in_data  = {9'h000, 9'h0FF};
    in_valid = 2'b01;
    step();
    in_valid = 2'b00;
    drive(12'hF05, 32'h0, 1'b0, 1'b1);
    step();
    chk("unmapped_f05", cpu_rdata, 32'h0);
    drive(12'hFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    #1;
    chk("top_ram_we", 32'(ram_we), 32'h0);
    step();
    chk("unmapped_fff", cpu_rdata, 32'h0);
    drive(12'hF10, 32'h0, 1'b0, 1'b1);
    step();
    chk("status_unchanged", cpu_rdata, 32'h1);
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_flags", 32'(dut.flag), 32'h0);
    step();
    reset = 1'b1;
    drive(12'hF10, 32'h0, 1'b0, 1'b1);
    step();
    chk("status_after_rst", cpu_rdata, 32'h0);
    drive(12'hF00, 32'h0, 1'b0, 1'b1);
    step();
    chk("sample_after_rst", cpu_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the processor's data-memory port and the rest of the system.
- Addresses below IO_BASE pass straight through to data RAM.
- Addresses at or above IO_BASE reach N_IN sensor input channels (accelerometer axes and similar), a status register, and N_OUT CPU-writable output registers (VGA sprite position and similar).
- Read data is returned with the same 1-cycle latency as RAM, so the processor sees one uniform memory.

Parameters:
- ADDR_W, 12, width of the CPU and RAM word addresses.
- DATA_W, 32, data width.
- N_IN, 2, number of sensor input channels (1..16).
- IN_W, 9, width of each input sample; samples are sign-extended to DATA_W.
- N_OUT, 4, number of output registers (1..16).
- IO_BASE, 12'hF00, first I/O word address.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  word address from the processor.
- cpu_wdata  in  DATA_W  write data.
- cpu_we  in  1  write enable.
- cpu_re  in  1  read qualifier; a load is in progress this cycle.
- cpu_rdata  out  DATA_W  read data, valid 1 cycle after the address.
- ram_addr  out  ADDR_W  copy of cpu_addr, passed combinationally.
- ram_wdata  out  DATA_W  copy of cpu_wdata.
- ram_we  out  1  cpu_we gated by (cpu_addr < IO_BASE).
- ram_rdata  in  DATA_W  RAM output, already registered by the RAM.
- in_data  in  N_IN*IN_W  packed samples; channel i occupies bits [i*IN_W +: IN_W].
- in_valid  in  N_IN  one-cycle capture strobe per channel.
- out_data  out  N_OUT*DATA_W  packed output registers.
- out_strobe  out  N_OUT  one-cycle pulse after each write to the matching output register.

Behaviour:
- I/O offset: off = cpu_addr - IO_BASE.
- Address map:
  - off 0..N_IN-1: input data register i. Read returns the sign-extended captured sample.
  - off 16: STATUS register. Bit i is the sticky new-sample flag of channel i; all other bits read 0.
  - off 32..32+N_OUT-1: output register j, read/write.
  - Any other I/O offset reads 0 and ignores writes.
- Writes to input registers or STATUS are ignored. STATUS is never cleared by a write.
- Reset (asynchronous, reset=0):
  - all captured samples, flags and output registers become 0;
  - out_strobe becomes 0;
  - the registered read-select becomes "RAM";
  - the registered I/O read value becomes 0.
  - Reset mid-transaction drops the transaction; the first cycle after release behaves as idle.
- Capture: when in_valid[i]=1, sample[i] <= in_data slice and flag[i] <= 1 at the next edge.
- Flag clear: flag[i] <= 0 at the edge ending a cycle with cpu_re=1 and cpu_addr = IO_BASE+i.
- Set/clear collision (capture and read of the same channel in the same cycle):
  - set wins; flag stays 1;
  - cpu_rdata next cycle returns the OLD sample;
  - the new sample is visible from the following read.
- Reading STATUS has no side effect.
- Output writes: cpu_we=1 with off=32+j updates out_reg[j] at the edge, and out_strobe[j]=1 for exactly the next cycle. Back-to-back writes give back-to-back pulses.
- Read path, latency 1:
  - at each edge, register is_io = (cpu_addr >= IO_BASE) and the selected I/O value;
  - cpu_rdata = is_io_q ? io_val_q : ram_rdata.
  - Results are the same with cpu_re=0; cpu_re only gates the flag-clear side effect.
- Simultaneous cpu_we and cpu_re to one output register: the read returns the pre-write value; the write takes effect at the edge.
- Address top (cpu_addr = 2^ADDR_W-1) is an unmapped I/O address and reads 0. There is no wrap-around into RAM.
- No state machine beyond these per-register flops. The block is fully pipelined and accepts a new access every cycle.

Decomposition:
- Package mmio_pkg holds:
  - offset constants: IN_OFF=0, STATUS_OFF=16, OUT_OFF=32;
  - the MAX_CH=16 limit;
  - a function sign_ext(sample, IN_W).
- Sub-module mmio_in_channel (one instance per input):
  - contains the sample register and sticky flag with set-priority logic;
  - ports: clock, reset, in_valid, in_sample, rd_clr, sample_q, flag_q.

Test Plan:
- Reset with out_reg[0]=5 previously written → out_data=0, out_strobe=0, and a read at F20 returns 0 on the cycle after the address.
- RAM pass-through: write 0xDEADBEEF to 0x010, then read 0x010 → ram_we=1 only on the write cycle; cpu_rdata=0xDEADBEEF one cycle after the read address; a write to 0xF20 gives ram_we=0.
- Capture and sign extension: in_valid[0] with in_data ch0=9'h1F0 → STATUS reads 0x1; a read of F00 returns 0xFFFFFFF0; a subsequent STATUS read returns 0x0.
- Collision: ch1 holds 9'h005 with flag set; in the same cycle in_valid[1] with 9'h007 and a read of F01 → the read returns 5, STATUS=0x2, and the next read of F01 returns 7.
- Output strobe: write 0x00000140 to F21 → out_data slice 1 = 0x140 and out_strobe=4'b0010 for exactly one cycle; writes to F00 and F10 leave their registers unchanged.
- Unmapped and top addresses: reads of F05 (N_IN=2) and FFF return 0 and no flag changes; an asynchronous reset asserted mid-cycle clears flags immediately, without waiting for a clock edge.
